fetch_unit: RTL and testbench

- Parametrised instruction-fetch front end; replaces the fixed PC register / PC+4 mux with a decoupled fetch stage.
- Issues sequential fetch requests to instruction memory with variable response latency, and buffers returned instructions with their PCs in an internal FIFO.
- Presents instructions to decode over a valid/ready handshake.
- Accepts a redirect (branch/jump target computed downstream) that flushes buffered and in-flight fetches.

---
 rtl/fetch_unit_if.sv | 32 +++
 rtl/fetch_unit.sv | 104 ++++++++++
 tb/tb_fetch_unit.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-unit signal bundle: memory request/response, decode delivery and redirect.
// master = the fetch unit itself, slave = memory/decode/branch environment.
interface fetch_unit_if #(
   parameter int XLEN = 32
);
   // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
   // A valid source holds its payload stable until the transfer; resp_valid has no
   // ready (the fetch unit always accepts, credits guarantee room).
   logic            req_valid;
   logic            req_ready;
   logic [XLEN-1:0] req_addr;
   logic            resp_valid;
   logic [XLEN-1:0] resp_data;
   logic            inst_valid;
   logic            inst_ready;
   logic [XLEN-1:0] inst_data;
   logic [XLEN-1:0] inst_pc;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_target;

   modport master (
      output req_valid, req_addr, inst_valid, inst_data, inst_pc,
      input  req_ready, resp_valid, resp_data, inst_ready,
             redirect_valid, redirect_target
   );

   modport slave (
      input  req_valid, req_addr, inst_valid, inst_data, inst_pc,
      output req_ready, resp_valid, resp_data, inst_ready,
             redirect_valid, redirect_target
   );
endinterface

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: credit-limited sequential requests, in-order responses
// paired with their PCs, an instruction FIFO towards decode, and redirect flushing.
module fetch_unit #(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int              FIFO_DEPTH = 4,
   parameter int              CW         = $clog2(FIFO_DEPTH) + 1
) (
   input logic        clk,
   input logic        rst,
   fetch_unit_if.master fu
);
   localparam int          AW      = $clog2(FIFO_DEPTH);
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

   logic [XLEN-1:0] fetch_pc, fetch_pc_n;
   logic [CW-1:0]   count, count_n;
   logic [CW-1:0]   outstanding, outstanding_n;
   logic [CW-1:0]   drop, drop_n;
   logic [AW-1:0]   rd_ptr, rd_ptr_n, wr_ptr, wr_ptr_n;
   logic [AW-1:0]   pcq_rd, pcq_wr;

   logic [XLEN-1:0] buf_pc   [FIFO_DEPTH];
   logic [XLEN-1:0] buf_inst [FIFO_DEPTH];
   logic [XLEN-1:0] pcq      [FIFO_DEPTH];

   logic [CW:0] credits_used;
   logic        issue, resp, pop, push;

   // Every buffered entry and every in-flight request holds one credit.
   assign credits_used = {1'b0, count} + {1'b0, outstanding};

   assign fu.req_valid  = !rst && !fu.redirect_valid && (credits_used < DEPTH_C);
   assign fu.req_addr   = fetch_pc;
   assign fu.inst_valid = !rst && !fu.redirect_valid && (count != '0);
   assign fu.inst_data  = buf_inst[rd_ptr];
   assign fu.inst_pc    = buf_pc[rd_ptr];

   assign issue = fu.req_valid && fu.req_ready;
   assign resp  = fu.resp_valid && !rst;
   assign pop   = fu.inst_valid && fu.inst_ready;
   assign push  = resp && (drop == '0) && !fu.redirect_valid;

   always_comb begin
      fetch_pc_n    = fetch_pc;
      count_n       = count;
      drop_n        = drop;
      rd_ptr_n      = rd_ptr;
      wr_ptr_n      = wr_ptr;
      outstanding_n = outstanding + CW'(issue) - CW'(resp);
      if (fu.redirect_valid) begin
         // Whatever is still in flight after this edge belongs to the old path.
         fetch_pc_n = fu.redirect_target & ~XLEN'(3);
         count_n    = '0;
         rd_ptr_n   = '0;
         wr_ptr_n   = '0;
         drop_n     = outstanding_n;
      end else begin
         if (issue) fetch_pc_n = fetch_pc + XLEN'(4);
         if (resp && (drop != '0)) drop_n = drop - CW'(1);
         if (push) wr_ptr_n = wr_ptr + AW'(1);
         if (pop) rd_ptr_n = rd_ptr + AW'(1);
         count_n = count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         count       <= '0;
         outstanding <= '0;
         drop        <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         pcq_rd      <= '0;
         pcq_wr      <= '0;
      end else begin
         fetch_pc    <= fetch_pc_n;
         count       <= count_n;
         outstanding <= outstanding_n;
         drop        <= drop_n;
         rd_ptr      <= rd_ptr_n;
         wr_ptr      <= wr_ptr_n;
         if (issue) pcq_wr <= pcq_wr + AW'(1);
         if (resp) pcq_rd <= pcq_rd + AW'(1);
      end
   end

   // Storage arrays need no reset: pointers and counts define what is live.
   always_ff @(posedge clk) begin
      if (issue) pcq[pcq_wr] <= fetch_pc;
      if (push) begin
         buf_pc[wr_ptr]   <= pcq[pcq_rd];
         buf_inst[wr_ptr] <= fu.resp_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(fu.resp_valid && (outstanding == '0)));
         assert (credits_used <= DEPTH_C);
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus hand-written corner sequences,
// with a latency-configurable in-order memory model and a PC scoreboard.
module tb_fetch_unit;
   localparam int XLEN  = 32;
   localparam int DEPTH = 4;

   logic clk;
   logic rst;

   fetch_unit_if #(.XLEN(XLEN)) bus ();

   fetch_unit #(
      .XLEN(XLEN), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .fu(bus)
   );

   typedef struct {
      logic        rst;
      logic        ir;
      logic        rv;
      logic [31:0] rt;
      logic        e_rv;
      logic [31:0] e_ra;
      logic        e_iv;
      logic [31:0] e_pc;
   } vec_t;

   typedef struct {
      int          due;
      logic [31:0] addr;
   } mem_t;

   vec_t        tbl[$];
   mem_t        mem_q[$];
   logic [31:0] exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          lat      = 1;
   logic        sb_on    = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      check(name, {31'd0, act}, {31'd0, exp});
   endtask

   // Drive this cycle's inputs at the negedge; memory presents a due response.
   task automatic drive(input logic r, input logic ir, input logic rv, input logic [31:0] rt);
      rst                 = r;
      bus.inst_ready      = ir;
      bus.redirect_valid  = rv;
      bus.redirect_target = rt;
      if (r) mem_q.delete();
      bus.resp_valid = 1'b0;
      bus.resp_data  = '0;
      if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
         bus.resp_valid = 1'b1;
         bus.resp_data  = inst_of(mem_q[0].addr);
         mem_q.delete(0);
      end
      #1;
   endtask

   // Record accepted requests and pops, then move to the next negedge.
   task automatic advance();
      mem_t m;
      if (!rst && bus.req_valid && bus.req_ready) begin
         m.due  = cyc + lat;
         m.addr = bus.req_addr;
         mem_q.push_back(m);
      end
      if (bus.inst_valid && bus.inst_ready) begin
         check("inst_data", bus.inst_data, inst_of(bus.inst_pc));
         if (sb_on) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_extra_pop (cycle %0d): got pc %h expected no instruction", cyc, bus.inst_pc);
            end else begin
               check("sb_pc", bus.inst_pc, exp_q.pop_front());
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b0, 1'b0, '0);
      advance();
      drive(1'b1, 1'b0, 1'b0, '0);
      check1("rst_req_valid", bus.req_valid, 1'b0);
      check1("rst_inst_valid", bus.inst_valid, 1'b0);
      advance();
   endtask

   task automatic add(input logic r, input logic ir, input logic rv, input logic [31:0] rt,
                      input logic erv, input logic [31:0] era, input logic eiv, input logic [31:0] epc);
      vec_t v;
      v = '{rst: r, ir: ir, rv: rv, rt: rt, e_rv: erv, e_ra: era, e_iv: eiv, e_pc: epc};
      tbl.push_back(v);
   endtask

   initial begin
      rst                 = 1'b1;
      bus.req_ready       = 1'b1;
      bus.resp_valid      = 1'b0;
      bus.resp_data       = '0;
      bus.inst_ready      = 1'b0;
      bus.redirect_valid  = 1'b0;
      bus.redirect_target = '0;
      @(negedge clk);

      // Free run with 1-cycle memory, then stall/drain from reset, then redirect and wrap.
      add(1, 1, 0, 0, 0, 0, 0, 0);
      add(1, 1, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 1, 32'h00, 0, 0);
      add(0, 1, 0, 0, 1, 32'h04, 0, 0);
      for (int k = 0; k < 6; k++)
         add(0, 1, 0, 0, 1, 32'(4 * (k + 2)), 1, 32'(4 * k));
      add(1, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 1, 32'h00, 0, 0);
      add(0, 0, 0, 0, 1, 32'h04, 0, 0);
      add(0, 0, 0, 0, 1, 32'h08, 1, 32'h0);
      add(0, 0, 0, 0, 1, 32'h0C, 1, 32'h0);
      for (int k = 0; k < 6; k++)
         add(0, 0, 0, 0, 0, 0, 1, 32'h0);
      add(0, 1, 0, 0, 0, 0, 1, 32'h0);
      for (int k = 0; k < 5; k++)
         add(0, 1, 0, 0, 1, 32'(32'h10 + 4 * k), 1, 32'(4 + 4 * k));
      add(0, 1, 1, 32'hFFFF_FFF8, 0, 0, 0, 0);
      add(0, 1, 0, 0, 1, 32'hFFFF_FFF8, 0, 0);
      add(0, 1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
      add(0, 1, 0, 0, 1, 32'h0000_0000, 1, 32'hFFFF_FFF8);
      add(0, 1, 0, 0, 1, 32'h0000_0004, 1, 32'hFFFF_FFFC);
      add(0, 1, 0, 0, 1, 32'h0000_0008, 1, 32'h0000_0000);

      lat = 1;
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rst, tbl[i].ir, tbl[i].rv, tbl[i].rt);
         check1($sformatf("tbl%0d_req_valid", i), bus.req_valid, tbl[i].e_rv);
         if (tbl[i].e_rv) check($sformatf("tbl%0d_req_addr", i), bus.req_addr, tbl[i].e_ra);
         check1($sformatf("tbl%0d_inst_valid", i), bus.inst_valid, tbl[i].e_iv);
         if (tbl[i].e_iv) check($sformatf("tbl%0d_inst_pc", i), bus.inst_pc, tbl[i].e_pc);
         advance();
      end

      // Latency 3: redirect while 0x10/0x14/0x18 are in flight.
      lat   = 3;
      exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100, 32'h104, 32'h108};
      sb_on = 1'b1;
      do_reset();
      for (int k = 0; k < 16; k++) begin
         drive(1'b0, 1'b1, (k == 8), 32'h100);
         if (k == 8) begin
            check1("l3_redir_req_valid", bus.req_valid, 1'b0);
            check1("l3_redir_inst_valid", bus.inst_valid, 1'b0);
         end
         if (k == 9) begin
            check1("l3_tgt_req_valid", bus.req_valid, 1'b1);
            check("l3_tgt_req_addr", bus.req_addr, 32'h100);
         end
         if (k >= 9 && k <= 12) check1("l3_dropped_inst_valid", bus.inst_valid, 1'b0);
         if (k == 13) begin
            check1("l3_first_inst_valid", bus.inst_valid, 1'b1);
            check("l3_first_inst_pc", bus.inst_pc, 32'h100);
         end
         advance();
      end
      check("l3_sb_drained", 32'(exp_q.size()), 32'd0);

      // Latency 2: redirect coinciding with a response and inst_ready, 2 entries buffered.
      lat   = 2;
      exp_q = '{32'h200, 32'h204};
      do_reset();
      for (int k = 0; k < 10; k++) begin
         drive(1'b0, (k >= 4), (k == 4), 32'h203);
         if (k == 3) begin
            check1("same_pre_inst_valid", bus.inst_valid, 1'b1);
            check("same_pre_inst_pc", bus.inst_pc, 32'h0);
         end
         if (k == 4) begin
            check1("same_redir_req_valid", bus.req_valid, 1'b0);
            check1("same_redir_inst_valid", bus.inst_valid, 1'b0);
         end
         if (k == 5) begin
            check1("same_tgt_req_valid", bus.req_valid, 1'b1);
            check("same_tgt_req_addr", bus.req_addr, 32'h200);
         end
         if (k >= 5 && k <= 7) check1("same_dropped_inst_valid", bus.inst_valid, 1'b0);
         if (k == 8) begin
            check1("same_first_inst_valid", bus.inst_valid, 1'b1);
            check("same_first_inst_pc", bus.inst_pc, 32'h200);
         end
         advance();
      end
      check("same_sb_drained", 32'(exp_q.size()), 32'd0);
      sb_on = 1'b0;

      // Reset with 3 buffered and 1 in flight; afterwards a full set of credits is available.
      lat = 3;
      do_reset();
      for (int k = 0; k < 12; k++) begin
         if (k == 7) lat = 1;
         drive((k == 6), 1'b0, 1'b0, '0);
         if (k == 5) begin
            check1("mid_pre_inst_valid", bus.inst_valid, 1'b1);
            check1("mid_pre_req_valid", bus.req_valid, 1'b0);
         end
         if (k == 6) begin
            check1("mid_rst_req_valid", bus.req_valid, 1'b0);
            check1("mid_rst_inst_valid", bus.inst_valid, 1'b0);
         end
         if (k == 7) check1("mid_post_inst_valid", bus.inst_valid, 1'b0);
         if (k >= 7 && k <= 10) begin
            check1("mid_post_req_valid", bus.req_valid, 1'b1);
            check("mid_post_req_addr", bus.req_addr, 32'(4 * (k - 7)));
         end
         if (k == 11) begin
            check1("mid_full_req_valid", bus.req_valid, 1'b0);
            check("mid_full_inst_pc", bus.inst_pc, 32'h0);
         end
         advance();
      end

      // Request back-pressure: address holds while req_ready is low.
      lat = 1;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         bus.req_ready = (k >= 2);
         drive(1'b0, 1'b1, 1'b0, '0);
         check1("bp_req_valid", bus.req_valid, 1'b1);
         check("bp_req_addr", bus.req_addr, (k == 3) ? 32'h4 : 32'h0);
         advance();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
